// File: rtl/spi_sram_responder.sv
// Serves memory-controller word requests from a 23LC1024-class SPI SRAM (mode 0, one frame each).
// Define SPI_SRAM_MODE_INIT_EN to send a WRMR (sequential mode) frame after reset.
module spi_sram_responder #(
   parameter int unsigned CLK_DIV        = 2,
   parameter int unsigned CS_HIGH_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        memory_we,
   input  logic [15:0] address_in,
   input  logic [15:0] wdata,
   output logic        off_chip_mem_ready,
   output logic [15:0] rdata,
   output logic        rdata_valid,
   output logic        spi_sck,
   output logic        spi_cs_n,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   typedef enum logic [1:0] {StIdle, StShift, StGap, StInit} state_t;

   localparam logic [15:0] DivLast = 16'(CLK_DIV - 1);
   localparam logic [15:0] GapLast = 16'(CS_HIGH_CYCLES - 1);

   state_t      state;
   logic [46:0] frame_sr;   // frame bits still to send, below the one currently on MOSI
   logic [15:0] miso_sr;
   logic [15:0] div_cnt;
   logic [15:0] gap_cnt;
   logic [5:0]  bit_cnt;
   logic [5:0]  last_bit;
   logic        is_read;
   logic [47:0] req_frame;

   assign req_frame = {(memory_we ? 8'h02 : 8'h03), 7'b0, address_in, 1'b0,
                       (memory_we ? wdata : 16'h0000)};

   always_ff @(posedge clk) begin
      if (reset) begin
`ifdef SPI_SRAM_MODE_INIT_EN
         state              <= StInit;
         off_chip_mem_ready <= 1'b0;
`else
         state              <= StIdle;
         off_chip_mem_ready <= 1'b1;
`endif
         spi_cs_n    <= 1'b1;
         spi_sck     <= 1'b0;
         spi_mosi    <= 1'b0;
         rdata       <= 16'h0000;
         rdata_valid <= 1'b0;
         frame_sr    <= '0;
         miso_sr     <= 16'h0000;
         div_cnt     <= 16'h0000;
         gap_cnt     <= 16'h0000;
         bit_cnt     <= 6'd0;
         last_bit    <= 6'd0;
         is_read     <= 1'b0;
      end else begin
         rdata_valid <= 1'b0;
         case (state)
            StIdle: begin
               if (req) begin
                  state              <= StShift;
                  off_chip_mem_ready <= 1'b0;
                  spi_cs_n           <= 1'b0;
                  spi_mosi           <= req_frame[47];
                  frame_sr           <= req_frame[46:0];
                  is_read            <= ~memory_we;
                  last_bit           <= 6'd47;
                  bit_cnt            <= 6'd0;
                  div_cnt            <= 16'h0000;
               end
            end
            StShift: begin
               if (div_cnt == DivLast) begin
                  div_cnt <= 16'h0000;
                  if (!spi_sck) begin
                     spi_sck <= 1'b1;
                     miso_sr <= {miso_sr[14:0], spi_miso};
                  end else begin
                     spi_sck <= 1'b0;
                     if (bit_cnt == last_bit) begin
                        state    <= StGap;
                        spi_cs_n <= 1'b1;
                        spi_mosi <= 1'b0;
                        gap_cnt  <= 16'h0000;
                        if (is_read) begin
                           rdata       <= miso_sr;
                           rdata_valid <= 1'b1;
                        end
                     end else begin
                        bit_cnt  <= bit_cnt + 6'd1;
                        spi_mosi <= frame_sr[46];
                        frame_sr <= {frame_sr[45:0], 1'b0};
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 16'h0001;
               end
            end
            StGap: begin
               if (gap_cnt == GapLast) begin
                  state              <= StIdle;
                  off_chip_mem_ready <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt + 16'h0001;
               end
            end
            default: begin
`ifdef SPI_SRAM_MODE_INIT_EN
               // WRMR 0x01, mode 0x40 as a 16-bit frame left-aligned in the shifter
               state    <= StShift;
               spi_cs_n <= 1'b0;
               spi_mosi <= 1'b0;
               frame_sr <= {15'h0140, 32'h0000_0000};
               is_read  <= 1'b0;
               last_bit <= 6'd15;
               bit_cnt  <= 6'd0;
               div_cnt  <= 16'h0000;
`else
               state              <= StIdle;
               off_chip_mem_ready <= 1'b1;
`endif
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder with a mode-0 serial SRAM read-data model.
module tb_spi_sram_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        memory_we;
   logic [15:0] address_in;
   logic [15:0] wdata;
   logic        off_chip_mem_ready;
   logic [15:0] rdata;
   logic        rdata_valid;
   logic        spi_sck;
   logic        spi_cs_n;
   logic        spi_mosi;
   logic        spi_miso;

   int tests = 0;
   int fails = 0;

   logic [47:0] cap;
   int          rises;
   int          falls;
   logic [15:0] miso_word;

   spi_sram_responder #(.CLK_DIV(2), .CS_HIGH_CYCLES(4)) dut (
      .clk                (clk),
      .reset              (reset),
      .req                (req),
      .memory_we          (memory_we),
      .address_in         (address_in),
      .wdata              (wdata),
      .off_chip_mem_ready (off_chip_mem_ready),
      .rdata              (rdata),
      .rdata_valid        (rdata_valid),
      .spi_sck            (spi_sck),
      .spi_cs_n           (spi_cs_n),
      .spi_mosi           (spi_mosi),
      .spi_miso           (spi_miso)
   );

   always #5 clk = ~clk;

   // MOSI as the device sees it
   always @(posedge spi_sck) begin
      if (!spi_cs_n) begin
         cap = {cap[46:0], spi_mosi};
         rises++;
      end
   end

   // Device shifts read data out on falling SCK once the 32 command/address bits are in
   always @(negedge spi_cs_n) falls = 0;
   always @(negedge spi_sck) begin
      if (!spi_cs_n) begin
         falls++;
         if (falls >= 32 && falls < 48) spi_miso = miso_word[47 - falls];
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] data);
      cap = '0;
      rises = 0;
      @(negedge clk);
      req = 1'b1;
      memory_we = we;
      address_in = addr;
      wdata = data;
      @(negedge clk);
      req = 1'b0;
   endtask

   // Starts at the sample just after the accept edge; runs until ready returns
   task automatic observe(output int cs_low, output int rdy_low, output int valids,
                          output int valid_on_rise, output bit timeout);
      logic prev_cs;
      cs_low = 0; rdy_low = 0; valids = 0; valid_on_rise = 0; timeout = 1'b1;
      prev_cs = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (off_chip_mem_ready) begin
            timeout = 1'b0;
            break;
         end
         if (!spi_cs_n) cs_low++;
         rdy_low++;
         if (rdata_valid) begin
            valids++;
            if (spi_cs_n && !prev_cs) valid_on_rise++;
         end
         prev_cs = spi_cs_n;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      logic prev_sck;
      int   toggles;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      prev_sck = 1'b0;
      toggles = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (spi_sck !== prev_sck) toggles++;
         prev_sck = spi_sck;
         tests++;
         if ({spi_cs_n, spi_sck, off_chip_mem_ready, rdata_valid, rdata} !== {4'b1010, 16'h0}) begin
            fails++;
            $display("FAIL reset_idle[%0d]: cs_n=%b sck=%b ready=%b valid=%b rdata=%h, want 1 0 1 0 0000",
                     i, spi_cs_n, spi_sck, off_chip_mem_ready, rdata_valid, rdata);
         end
      end
      tests++;
      if (toggles !== 0) begin
         fails++;
         $display("FAIL reset_sck_toggles: got %0d want 0", toggles);
      end
   endtask

`ifdef SPI_SRAM_MODE_INIT_EN
   task automatic test_init;
      int cs_low, rdy_low, valids, vrise;
      bit to;
      cap = '0;
      rises = 0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req = 1'b1;
      memory_we = 1'b1;
      address_in = 16'h1111;
      wdata = 16'h2222;
      @(negedge clk);
      tests++;
      if (off_chip_mem_ready !== 1'b0) begin
         fails++;
         $display("FAIL init_ready_low: got %b want 0", off_chip_mem_ready);
      end
      repeat (10) @(negedge clk);
      req = 1'b0;
      observe(cs_low, rdy_low, valids, vrise, to);
      repeat (20) @(negedge clk);
      tests++;
      if ({to, rises, cap[15:0]} !== {1'b0, 32'd16, 16'h0140}) begin
         fails++;
         $display("FAIL init_frame: timeout=%b rises=%0d frame=%h, want 0 16 0140", to, rises, cap[15:0]);
      end
   endtask
`endif

   task automatic test_write(input logic [15:0] addr, input logic [15:0] data,
                             input logic [23:0] exp_addr, input logic [15:0] exp_rdata);
      int cs_low, rdy_low, valids, vrise;
      bit to;
      issue(1'b1, addr, data);
      tests++;
      if (spi_cs_n !== 1'b0 || off_chip_mem_ready !== 1'b0) begin
         fails++;
         $display("FAIL wr_start: cs_n=%b ready=%b want 0 0", spi_cs_n, off_chip_mem_ready);
      end
      observe(cs_low, rdy_low, valids, vrise, to);
      tests++;
      if (to !== 1'b0) begin fails++; $display("FAIL wr_timeout: ready never returned"); end
      tests++;
      if (cap[47:40] !== 8'h02) begin fails++; $display("FAIL wr_cmd: got %h want 02", cap[47:40]); end
      tests++;
      if (cap[39:16] !== exp_addr) begin
         fails++; $display("FAIL wr_addr: got %h want %h", cap[39:16], exp_addr);
      end
      tests++;
      if (cap[15:0] !== data) begin fails++; $display("FAIL wr_data: got %h want %h", cap[15:0], data); end
      tests++;
      if (rises !== 48) begin fails++; $display("FAIL wr_bits: got %0d want 48", rises); end
      tests++;
      if (cs_low !== 192) begin fails++; $display("FAIL wr_cs_low: got %0d want 192", cs_low); end
      // ready is up for the 197th edge after accept
      tests++;
      if (rdy_low !== 196) begin fails++; $display("FAIL wr_ready_low: got %0d want 196", rdy_low); end
      tests++;
      if (valids !== 0 || rdata !== exp_rdata) begin
         fails++;
         $display("FAIL wr_rdata_hold: valids=%0d rdata=%h want 0 %h", valids, rdata, exp_rdata);
      end
   endtask

   task automatic test_read(input logic [15:0] addr, input logic [23:0] exp_addr,
                            input logic [15:0] word);
      int cs_low, rdy_low, valids, vrise;
      bit to;
      miso_word = word;
      issue(1'b0, addr, 16'hFFFF);
      observe(cs_low, rdy_low, valids, vrise, to);
      tests++;
      if (to !== 1'b0) begin fails++; $display("FAIL rd_timeout: ready never returned"); end
      tests++;
      if (cap[47:40] !== 8'h03) begin fails++; $display("FAIL rd_cmd: got %h want 03", cap[47:40]); end
      tests++;
      if (cap[39:16] !== exp_addr) begin
         fails++; $display("FAIL rd_addr: got %h want %h", cap[39:16], exp_addr);
      end
      tests++;
      if (cap[15:0] !== 16'h0000) begin fails++; $display("FAIL rd_mosi_zero: got %h want 0000", cap[15:0]); end
      tests++;
      if (rdata !== word) begin fails++; $display("FAIL rd_data: got %h want %h", rdata, word); end
      tests++;
      if (valids !== 1 || vrise !== 1) begin
         fails++; $display("FAIL rd_valid: pulses=%0d at_cs_rise=%0d want 1 1", valids, vrise);
      end
      tests++;
      if (cs_low !== 192) begin fails++; $display("FAIL rd_cs_low: got %0d want 192", cs_low); end
   endtask

   task automatic test_back_to_back;
      int  fall_at [3];
      int  nf, rises_at_second;
      int  cs_low, rdy_low, valids, vrise;
      bit  to;
      logic prev;
      cap = '0;
      rises = 0;
      nf = 0;
      rises_at_second = -1;
      fall_at = '{-1, -1, -1};
      @(negedge clk);
      req = 1'b1;
      memory_we = 1'b1;
      address_in = 16'h0042;
      wdata = 16'h1357;
      @(negedge clk);
      prev = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if (prev && !spi_cs_n) begin
            if (nf < 3) fall_at[nf] = i;
            if (nf == 1) rises_at_second = rises;
            nf++;
         end
         prev = spi_cs_n;
         @(negedge clk);
      end
      req = 1'b0;
      observe(cs_low, rdy_low, valids, vrise, to);
      tests++;
      if (nf !== 3) begin fails++; $display("FAIL b2b_count: got %0d frames want 3", nf); end
      tests++;
      if (fall_at[1] - fall_at[0] !== 197 || fall_at[2] - fall_at[1] !== 197) begin
         fails++;
         $display("FAIL b2b_period: starts %0d %0d %0d want spacing 197",
                  fall_at[0], fall_at[1], fall_at[2]);
      end
      tests++;
      if (rises_at_second !== 48) begin
         fails++; $display("FAIL b2b_single_frame: got %0d bits want 48", rises_at_second);
      end
      tests++;
      if (to !== 1'b0) begin fails++; $display("FAIL b2b_timeout: ready never returned"); end
   endtask

   task automatic test_reset_abort;
      int   valids, toggles;
      logic prev_sck;
      miso_word = 16'h1234;
      issue(1'b0, 16'h0100, 16'h0000);
      repeat (49) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      tests++;
      if (spi_cs_n !== 1'b1 || spi_sck !== 1'b0 || rdata_valid !== 1'b0) begin
         fails++;
         $display("FAIL abort_immediate: cs_n=%b sck=%b valid=%b want 1 0 0",
                  spi_cs_n, spi_sck, rdata_valid);
      end
      reset = 1'b0;
      valids = 0;
      toggles = 0;
      prev_sck = 1'b0;
      for (int i = 0; i < 250; i++) begin
         @(negedge clk);
         if (rdata_valid) valids++;
         if (spi_sck !== prev_sck) toggles++;
         prev_sck = spi_sck;
      end
      tests++;
      if (valids !== 0 || toggles !== 0) begin
         fails++; $display("FAIL abort_quiet: valids=%0d sck_toggles=%0d want 0 0", valids, toggles);
      end
      tests++;
      if (rdata !== 16'h0000 || off_chip_mem_ready !== 1'b1 || spi_cs_n !== 1'b1) begin
         fails++;
         $display("FAIL abort_state: rdata=%h ready=%b cs_n=%b want 0000 1 1",
                  rdata, off_chip_mem_ready, spi_cs_n);
      end
   endtask

   initial begin
      reset = 1'b1;
      req = 1'b0;
      memory_we = 1'b0;
      address_in = 16'h0000;
      wdata = 16'h0000;
      spi_miso = 1'b0;
      miso_word = 16'h0000;
      cap = '0;
      rises = 0;
      falls = 0;
`ifdef SPI_SRAM_MODE_INIT_EN
      test_init;
`else
      test_reset;
`endif
      test_write(16'h1234, 16'hBEEF, 24'h002468, 16'h0000);
      test_read(16'hFFFF, 24'h01FFFE, 16'hA5C3);
      test_write(16'h8001, 16'h0001, 24'h010002, 16'hA5C3);
      test_read(16'h00FF, 24'h0001FE, 16'h0F0F);
      test_back_to_back;
      test_reset_abort;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
